vga_timing_gen: RTL

//  640x480@60 Hz raster timing generator feeding Module_VGA_Control: divides 50 MHz Clock to a 25 MHz

---
 rtl/vga_timing_gen_pkg.sv | 32 +++
 rtl/vga_wrap_counter.sv | 42 ++++
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing defaults, RGB payload type and a window-compare helper.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W_DEF     = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // One bit per DAC channel
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t COLOR_BLACK = '{r: 1'b0, g: 1'b0, b: 1'b0};

  // True when lo <= v <= hi
  function automatic logic in_window(input int unsigned v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter 0..MAX that wraps to 0; any value >= MAX returns to 0 on the next enable.
module vga_wrap_counter #(
  parameter int unsigned MAX = 799,
  parameter int unsigned W   = 10
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         iEnable,
  output logic [W-1:0] oCount,
  output logic         oWrap
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: hold, increment, or wrap (also recovers from out-of-range values)
  always_comb begin
    count_d = count_q;
    if (iEnable) begin
      if (count_q >= MAX_W) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oCount = count_q;
  assign oWrap  = (count_q >= MAX_W);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel enable, col/row counters, registered syncs and blanked RGB.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iCrvgaR,
  input  logic             iCrvgaG,
  input  logic             iCrvgaB,
  output logic             oCrvgaR,
  output logic             oCrvgaG,
  output logic             oCrvgaB,
  output logic             hoz_sync,
  output logic             ver_sync,
  output logic [CNT_W-1:0] oCurrentCol,
  output logic [CNT_W-1:0] oCurrentRow,
  output logic             oPixelEnable,
  output logic             oActive,
  output logic             oFrameStart
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_VIS_W = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_W = CNT_W'(V_VISIBLE);

  logic             pix_en_q;
  logic             pix_en_d;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             h_wrap;
  logic             v_en_c;
  logic             v_wrap_unused;
  logic             active_c;
  logic             hs_q;
  logic             hs_d;
  logic             vs_q;
  logic             vs_d;
  rgb_t             rgb_q;
  rgb_t             rgb_d;

  // 25 MHz pixel strobe: toggle every Clock, enable on the high phase
  always_comb begin
    pix_en_d = ~pix_en_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
    end
  end

  vga_wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (CNT_W)
  ) u_h_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .iEnable (pix_en_q),
    .oCount  (col),
    .oWrap   (h_wrap)
  );

  assign v_en_c = h_wrap & pix_en_q;

  vga_wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (CNT_W)
  ) u_v_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .iEnable (v_en_c),
    .oCount  (row),
    .oWrap   (v_wrap_unused)
  );

  assign active_c = (col < H_VIS_W) && (row < V_VIS_W);

  // Sync and blanked colour from pre-increment counters, updated on pixel enables only
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (pix_en_q) begin
      hs_d  = ~in_window(32'(col), HS_START, HS_END);
      vs_d  = ~in_window(32'(row), VS_START, VS_END);
      rgb_d = active_c ? rgb_t'({iCrvgaR, iCrvgaG, iCrvgaB}) : COLOR_BLACK;
    end
  end

  // Output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= COLOR_BLACK;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign hoz_sync     = hs_q;
  assign ver_sync     = vs_q;
  assign oCrvgaR      = rgb_q.r;
  assign oCrvgaG      = rgb_q.g;
  assign oCrvgaB      = rgb_q.b;
  assign oCurrentCol  = col;
  assign oCurrentRow  = row;
  assign oPixelEnable = pix_en_q;
  assign oActive      = active_c;
  assign oFrameStart  = pix_en_q && (col == '0) && (row == '0);

endmodule
